// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the accumulator microcontroller execution core.
//   - stage encodings of the LOAD/FETCH/DECODE/EXECUTE sequence
//   - control opcodes (ir[11:8])
//   - ALU mode enumeration
//   - status-register flag bit positions, sr = {Z,C,S,V}
//   - skip_taken(): skip-instruction condition evaluation
package mc_pkg;

  typedef enum logic [1:0] {
    STG_LOAD    = 2'b00,
    STG_FETCH   = 2'b01,
    STG_DECODE  = 2'b10,
    STG_EXECUTE = 2'b11
  } stage_t;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_GO    = 4'b0001;
  localparam logic [3:0] OP_SZ    = 4'b0010;
  localparam logic [3:0] OP_SC    = 4'b0011;
  localparam logic [3:0] OP_SS    = 4'b0100;
  localparam logic [3:0] OP_SV    = 4'b0101;
  localparam logic [3:0] OP_PRINT = 4'b0110;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_RSB   = 4'h2,
    ALU_PASSB = 4'h3,
    ALU_AND   = 4'h4,
    ALU_OR    = 4'h5,
    ALU_XOR   = 4'h6,
    ALU_NOTB  = 4'h7,
    ALU_SHL   = 4'h8,
    ALU_SHR   = 4'h9,
    ALU_ROL   = 4'hA,
    ALU_ROR   = 4'hB,
    ALU_INCB  = 4'hC,
    ALU_DECB  = 4'hD,
    ALU_NOTA  = 4'hE,
    ALU_PASSA = 4'hF
  } alu_mode_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_V = 0;

  // A skip instruction is taken when its selected flag is set.
  function automatic logic skip_taken(input logic [3:0] op, input logic [3:0] sr);
    logic taken;
    taken = 1'b0;
    case (op)
      OP_SZ:   taken = sr[FLAG_Z];
      OP_SC:   taken = sr[FLAG_C];
      OP_SS:   taken = sr[FLAG_S];
      OP_SV:   taken = sr[FLAG_V];
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/mc_exec_core_alu.sv
// mc_alu: combinational ALU with flag generation.
//   en       in   1      ALU active; when 0, alu_out = 0 and sr_new = sr
//   mode     in   4      operation select (alu_mode_t)
//   a, b     in   DATA_W operands (a = accumulator)
//   sr       in   4      current flags {Z,C,S,V}
//   alu_out  out  DATA_W result
//   sr_new   out  4      new flags {Z,C,S,V}; C/V pass through for modes
//                        that do not define them
module mc_alu
  import mc_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              en,
  input  alu_mode_t         mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        sr,
  output logic [DATA_W-1:0] alu_out,
  output logic [3:0]        sr_new
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0]   wide;
  logic [DATA_W-1:0] res;
  logic              c;
  logic              v;

  always_comb begin
    wide    = '0;
    res     = '0;
    c       = sr[FLAG_C];
    v       = sr[FLAG_V];
    alu_out = '0;
    sr_new  = sr;
    if (en) begin
      case (mode)
        ALU_ADD: begin
          wide = {1'b0, a} + {1'b0, b};
          res  = wide[MSB:0];
          c    = wide[DATA_W];
          v    = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
        end
        // Subtracts: bit 8 of the 9-bit difference is the borrow.
        ALU_SUB: begin
          wide = {1'b0, a} - {1'b0, b};
          res  = wide[MSB:0];
          c    = wide[DATA_W];
          v    = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
        end
        ALU_RSB: begin
          wide = {1'b0, b} - {1'b0, a};
          res  = wide[MSB:0];
          c    = wide[DATA_W];
          v    = (a[MSB] != b[MSB]) && (res[MSB] != b[MSB]);
        end
        ALU_PASSB: res = b;
        ALU_AND:   res = a & b;
        ALU_OR:    res = a | b;
        ALU_XOR:   res = a ^ b;
        ALU_NOTB:  res = ~b;
        // Shifts and rotates report the bit that falls off in C.
        ALU_SHL: begin
          res = {a[MSB-1:0], 1'b0};
          c   = a[MSB];
        end
        ALU_SHR: begin
          res = {1'b0, a[MSB:1]};
          c   = a[0];
        end
        ALU_ROL: begin
          res = {a[MSB-1:0], a[MSB]};
          c   = a[MSB];
        end
        ALU_ROR: begin
          res = {a[0], a[MSB:1]};
          c   = a[0];
        end
        ALU_INCB: begin
          wide = {1'b0, b} + (DATA_W+1)'(1);
          res  = wide[MSB:0];
          c    = wide[DATA_W];
          v    = ~b[MSB] & res[MSB];
        end
        ALU_DECB: begin
          wide = {1'b0, b} - (DATA_W+1)'(1);
          res  = wide[MSB:0];
          c    = wide[DATA_W];
          v    = b[MSB] & ~res[MSB];
        end
        ALU_NOTA:  res = ~a;
        ALU_PASSA: res = a;
        default:   res = '0;
      endcase
      alu_out = res;
      sr_new  = {(res == '0), c, res[MSB], v};
    end
  end

endmodule

// File: rtl/mc_exec_core.sv
// mc_exec_core: execution core of the 8-bit accumulator microcontroller.
//   clk, rst            clock (rising edge); asynchronous active-low reset
//   stage               00 LOAD, 01 FETCH, 10 DECODE, 11 EXECUTE
//   ir, acc, dr, sr     instruction, accumulator, data register, flags {Z,C,S,V}
//   pc_e..dr_e          register load enables
//   pmem_e, pmem_le     program-memory read / load enables
//   mux1_sel            1: next PC = ir[7:0], 0: next PC = PC+1
//   alu_out, sr_new     ALU result and flags
//   dmem_rdata          mem[ir[3:0]] (combinational read)
//   print_data,print_en print value mem[ir[3:0]] and its strobe
module mc_exec_core
  import mc_pkg::*;
#(
  parameter int DMEM_DEPTH = 16,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        stage,
  input  logic [11:0]       ir,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] dr,
  input  logic [3:0]        sr,
  output logic              pc_e,
  output logic              acc_e,
  output logic              sr_e,
  output logic              ir_e,
  output logic              dr_e,
  output logic              pmem_e,
  output logic              pmem_le,
  output logic              mux1_sel,
  output logic [DATA_W-1:0] alu_out,
  output logic [3:0]        sr_new,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] print_data,
  output logic              print_en
);

  localparam int ADDR_W = $clog2(DMEM_DEPTH);

  logic              is_itype;
  logic              is_mtype;
  logic              alu_class;
  logic              alu_en;
  logic              mem_we;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] addr;
  alu_mode_t         alu_mode;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] mem_reg [DMEM_DEPTH];

  assign is_itype  = ir[11];
  assign is_mtype  = (ir[11:10] == 2'b01);
  assign alu_class = is_itype | is_mtype;
  assign opcode    = ir[11:8];
  assign addr      = ir[ADDR_W-1:0];

  // Control opcodes are matched on ir[11:8] alone. SS/SV/PRINT share
  // encodings with M-type words, so both decodes apply to those words; the
  // enables they drive never conflict.
  assign alu_en   = (stage_t'(stage) == STG_EXECUTE) && alu_class;
  assign alu_mode = is_mtype ? alu_mode_t'(ir[7:4]) : alu_mode_t'({1'b0, ir[10:8]});
  assign alu_b    = is_mtype ? dr : DATA_W'(ir[7:0]);
  assign mem_we   = (stage_t'(stage) == STG_EXECUTE) && is_mtype && ir[9];

  mc_alu #(.DATA_W(DATA_W)) u_alu (
    .en      (alu_en),
    .mode    (alu_mode),
    .a       (acc),
    .b       (alu_b),
    .sr      (sr),
    .alu_out (alu_out),
    .sr_new  (sr_new)
  );

  always_comb begin
    pc_e     = 1'b0;
    acc_e    = 1'b0;
    sr_e     = 1'b0;
    ir_e     = 1'b0;
    dr_e     = 1'b0;
    pmem_e   = 1'b0;
    pmem_le  = 1'b0;
    mux1_sel = 1'b0;
    print_en = 1'b0;
    if (rst) begin
      case (stage_t'(stage))
        STG_LOAD: begin
          pmem_le = 1'b1;
          pmem_e  = 1'b1;
        end
        STG_FETCH: begin
          ir_e   = 1'b1;
          pmem_e = 1'b1;
        end
        // A taken skip bumps PC here and again in EXECUTE: PC advances by 2.
        STG_DECODE: begin
          dr_e = is_mtype;
          pc_e = skip_taken(opcode, sr);
        end
        STG_EXECUTE: begin
          pc_e     = 1'b1;
          mux1_sel = (opcode == OP_GO);
          sr_e     = alu_class;
          acc_e    = alu_class & ~(is_mtype & ir[9]);
          print_en = (opcode == OP_PRINT);
        end
        default: ;
      endcase
    end
  end

  // Reset clears every word; the write is suppressed while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DMEM_DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (mem_we) begin
      mem_reg[addr] <= alu_out;
    end
  end

  // Combinational read returns pre-write data during a same-address write.
  assign dmem_rdata = mem_reg[addr];
  assign print_data = mem_reg[addr];

endmodule

// File: tb/tb_mc_exec_core.sv
module tb_mc_exec_core;

  logic        clk;
  logic        rst;
  logic [1:0]  stage;
  logic [11:0] ir;
  logic [7:0]  acc;
  logic [7:0]  dr;
  logic [3:0]  sr;
  logic        pc_e, acc_e, sr_e, ir_e, dr_e, pmem_e, pmem_le, mux1_sel, print_en;
  logic [7:0]  alu_out, dmem_rdata, print_data;
  logic [3:0]  sr_new;

  mc_exec_core dut (
    .clk        (clk),
    .rst        (rst),
    .stage      (stage),
    .ir         (ir),
    .acc        (acc),
    .dr         (dr),
    .sr         (sr),
    .pc_e       (pc_e),
    .acc_e      (acc_e),
    .sr_e       (sr_e),
    .ir_e       (ir_e),
    .dr_e       (dr_e),
    .pmem_e     (pmem_e),
    .pmem_le    (pmem_le),
    .mux1_sel   (mux1_sel),
    .alu_out    (alu_out),
    .sr_new     (sr_new),
    .dmem_rdata (dmem_rdata),
    .print_data (print_data),
    .print_en   (print_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enable vector order: {pc,acc,sr,ir,dr,pmem,pmem_le,mux1,print}
  typedef struct {
    string       tag;
    logic        chk_alu;
    logic [8:0]  en;
    logic [7:0]  alu_out;
    logic [3:0]  sr_new;
    logic [7:0]  rdata;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] ref_mem [16];
  int         tests_run    = 0;
  int         tests_failed = 0;
  int         txn_no       = 0;

  // Reference ALU in plain integer arithmetic.
  function automatic void ref_alu(input logic [3:0] mode, input logic [7:0] a, input logic [7:0] b,
                                  input logic [3:0] s, output logic [7:0] out, output logic [3:0] fl);
    int   ua, ub, sa, sb, res, sres;
    logic c, v;
    bit   arith;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    c = s[2]; v = s[0]; arith = 0; res = 0; sres = 0;
    case (mode)
      4'h0: begin res = ua + ub; sres = sa + sb; c = (res > 255); arith = 1; end
      4'h1: begin res = ua - ub; sres = sa - sb; c = (ua < ub);   arith = 1; end
      4'h2: begin res = ub - ua; sres = sb - sa; c = (ub < ua);   arith = 1; end
      4'h3: res = ub;
      4'h4: res = ua & ub;
      4'h5: res = ua | ub;
      4'h6: res = ua ^ ub;
      4'h7: res = 255 - ub;
      4'h8: begin res = ua * 2;                   c = (ua >= 128);     end
      4'h9: begin res = ua / 2;                   c = ((ua % 2) == 1); end
      4'hA: begin res = (ua * 2) % 256 + ua / 128; c = (ua >= 128);     end
      4'hB: begin res = ua / 2 + (ua % 2) * 128;   c = ((ua % 2) == 1); end
      4'hC: begin res = ub + 1; sres = sb + 1; c = (res > 255); arith = 1; end
      4'hD: begin res = ub - 1; sres = sb - 1; c = (ub == 0);   arith = 1; end
      4'hE: res = 255 - ua;
      default: res = ua;
    endcase
    if (arith) v = (sres > 127) || (sres < -128);
    out = 8'(res & 255);
    fl  = {(out == 8'h00), c, (out >= 8'h80), v};
  endfunction

  function automatic exp_t model(input logic r, input logic [1:0] st, input logic [11:0] i,
                                 input logic [7:0] a, input logic [7:0] d, input logic [3:0] s,
                                 input string tag);
    exp_t       e;
    int         op;
    bit         is_i, is_m, skip;
    bit         p_pc, p_acc, p_sr, p_ir, p_dr, p_pm, p_pml, p_mux, p_pr;
    logic [7:0] out;
    logic [3:0] fl;
    e.tag = tag; e.chk_alu = r; e.en = '0; e.alu_out = '0; e.sr_new = '0;
    if (!r) begin
      foreach (ref_mem[k]) ref_mem[k] = 8'h00;
      e.rdata = 8'h00;
      return e;
    end
    op   = int'(i[11:8]);
    is_i = i[11];
    is_m = (i[11:10] == 2'b01);
    skip = (op >= 2 && op <= 5) && s[5 - op];
    {p_pc, p_acc, p_sr, p_ir, p_dr, p_pm, p_pml, p_mux, p_pr} = '0;
    case (st)
      2'd0: begin p_pml = 1; p_pm = 1; end
      2'd1: begin p_ir = 1; p_pm = 1; end
      2'd2: begin p_dr = is_m; p_pc = skip; end
      default: begin
        p_pc  = 1;
        p_mux = (op == 1);
        p_pr  = (op == 6);
        if (is_i || is_m) begin
          p_sr  = 1;
          p_acc = !(is_m && i[9]);
        end
      end
    endcase
    e.en = {p_pc, p_acc, p_sr, p_ir, p_dr, p_pm, p_pml, p_mux, p_pr};
    if (st == 2'd3 && (is_i || is_m))
      ref_alu(is_m ? i[7:4] : {1'b0, i[10:8]}, a, is_m ? d : i[7:0], s, out, fl);
    else begin
      out = 8'h00;
      fl  = s;
    end
    e.alu_out = out;
    e.sr_new  = fl;
    e.rdata   = ref_mem[i[3:0]];
    if (st == 2'd3 && is_m && i[9]) ref_mem[i[3:0]] = out;
    return e;
  endfunction

  task automatic issue(input logic r, input logic [1:0] st, input logic [11:0] i,
                       input logic [7:0] a, input logic [7:0] d, input logic [3:0] s,
                       input string tag);
    @(posedge clk);
    #1;
    rst = r; stage = st; ir = i; acc = a; dr = d; sr = s;
    sb_q.push_back(model(r, st, i, a, d, s, tag));
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t       e;
    logic [8:0] got_en;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      txn_no++;
      got_en = {pc_e, acc_e, sr_e, ir_e, dr_e, pmem_e, pmem_le, mux1_sel, print_en};
      $display("[TB] txn %0d %s rst=%b stage=%0d ir=%h acc=%h dr=%h sr=%b en=%b alu=%h flags=%b rd=%h",
               txn_no, e.tag, rst, stage, ir, acc, dr, sr, got_en, alu_out, sr_new, dmem_rdata);
      tests_run++;
      if (got_en !== e.en) begin
        tests_failed++;
        $display("FAIL %s enables: got %b expected %b", e.tag, got_en, e.en);
      end
      tests_run++;
      if (dmem_rdata !== e.rdata || print_data !== e.rdata) begin
        tests_failed++;
        $display("FAIL %s mem_read: got rdata=%h print=%h expected %h", e.tag, dmem_rdata, print_data, e.rdata);
      end
      if (e.chk_alu) begin
        tests_run++;
        if (alu_out !== e.alu_out || sr_new !== e.sr_new) begin
          tests_failed++;
          $display("FAIL %s alu: got out=%h flags=%b expected out=%h flags=%b",
                   e.tag, alu_out, sr_new, e.alu_out, e.sr_new);
        end
      end
    end
  end

  initial begin : stimulus
    int guard;
    rst = 1'b0; stage = 2'd0; ir = 12'h000; acc = 8'h00; dr = 8'h00; sr = 4'h0;

    // Reset: every stage, including an EXECUTE store, must yield no enables.
    issue(0, 2'd0, 12'h000, 8'h00, 8'h00, 4'h0, "rst_load");
    issue(0, 2'd1, 12'h123, 8'h00, 8'h00, 4'h0, "rst_fetch");
    issue(0, 2'd2, 12'h200, 8'h00, 8'h00, 4'hF, "rst_skip");
    issue(0, 2'd3, 12'h605, 8'h03, 8'h05, 4'h0, "rst_store");

    for (int a = 0; a < 16; a++) issue(1, 2'd0, 12'(a), 8'h00, 8'h00, 4'h0, "rd_zero");

    issue(1, 2'd3, 12'h801, 8'h7F, 8'h00, 4'h0, "i_add");
    issue(1, 2'd3, 12'h605, 8'h03, 8'h05, 4'h0, "m_store");
    issue(1, 2'd3, 12'h605, 8'h03, 8'h05, 4'h0, "print");
    issue(1, 2'd3, 12'h902, 8'h01, 8'h00, 4'h0, "i_sub");
    issue(1, 2'd3, 12'h410, 8'h01, 8'h02, 4'h0, "m_sub");
    issue(1, 2'd2, 12'h2AB, 8'h00, 8'h00, 4'h8, "sz_dec");
    issue(1, 2'd3, 12'h2AB, 8'h00, 8'h00, 4'h8, "sz_exe");
    issue(1, 2'd2, 12'h2AB, 8'h00, 8'h00, 4'h0, "sz_ndec");
    issue(1, 2'd3, 12'h2AB, 8'h00, 8'h00, 4'h0, "sz_nexe");
    issue(1, 2'd3, 12'h120, 8'h00, 8'h00, 4'h0, "go");
    issue(1, 2'd1, 12'h120, 8'h00, 8'h00, 4'h0, "fetch");
    issue(1, 2'd0, 12'h120, 8'h00, 8'h00, 4'h0, "load");
    issue(1, 2'd2, 12'h437, 8'h00, 8'h00, 4'h0, "m_decode");

    // Reset in the middle of an EXECUTE store clears memory and blocks the write.
    issue(1, 2'd3, 12'h607, 8'h10, 8'h20, 4'h0, "st_pre");
    issue(0, 2'd3, 12'h607, 8'h11, 8'h22, 4'h0, "st_rst");
    issue(1, 2'd0, 12'h007, 8'h00, 8'h00, 4'h0, "st_chk");

    for (int n = 0; n < 400; n++) begin
      issue(($urandom_range(0, 39) != 0), 2'($urandom_range(0, 3)), 12'($urandom),
            8'($urandom), 8'($urandom), 4'($urandom), "random");
    end
    // Exercise every M-type mode with stores so memory contents evolve.
    for (int m = 0; m < 16; m++) begin
      issue(1, 2'd3, {4'b0110, 4'(m), 4'($urandom)}, 8'($urandom), 8'($urandom), 4'($urandom), "m_mode");
      issue(1, 2'd3, {4'b0100, 4'(m), 4'($urandom)}, 8'($urandom), 8'($urandom), 4'($urandom), "m_acc");
    end

    guard = 0;
    while (sb_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (sb_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
